rr_enable_arbiter: RTL and testbench
====================================

Name: rr_enable_arbiter

Overview:
Round-robin arbiter and sequencer that shares a single enabled, asynchronously reset data register among N_REQ requesters. It selects one requester at a time, drives the register's clock enable for exactly one cycle to capture that requester's data, and acknowledges it. A four-phase req/ack handshake per requester closes each transfer. The block sits in front of a shared rising-edge flip-flop bank and owns that bank's enable.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 8, width of shared register and each requester's data
IDX_W, $clog2(N_REQ), width of the winner index and priority pointer (derived, not overridable)

Ports:
iClock  in  1  rising-edge clock
iReset  in  1  asynchronous, active-low reset
iReq  in  N_REQ  per-requester request, level, held until ack
iData  in  N_REQ*DATA_W  requester k data in bits [k*DATA_W +: DATA_W]
oGrant  out  N_REQ  one-hot grant, registered
oAck  out  N_REQ  one-cycle pulse, data captured for requester k
oEnable  out  1  shared register enable, one-cycle pulse coincident with capture
oQ  out  DATA_W  shared register contents
oBusy  out  1  high in any state other than IDLE

Behaviour:
- Reset: iReset low asynchronously forces state=IDLE, oGrant=0, oAck=0, oEnable=0, oQ=0, oBusy=0, pointer=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, GRANT, CAPTURE, RELEASE.
- IDLE: if any iReq bit is set, choose the first set bit searching circularly from pointer+1 (mod N_REQ). Register winner and set oGrant[winner]. Go to GRANT. Otherwise stay in IDLE.
- GRANT: if iReq[winner] is still high, go to CAPTURE. If it has dropped (abort), clear oGrant, set pointer=winner, and go to IDLE with no capture and no ack.
- CAPTURE (one cycle): oEnable=1. At the clock edge ending this state, oQ <= iData[winner]. oAck[winner]=1 for this cycle only. Set pointer=winner. Go to RELEASE.
- RELEASE: hold oGrant. Wait until iReq[winner]=0, then clear oGrant and go to IDLE. Other requests stay pending and are not reordered.
- oQ changes only at a CAPTURE edge or on reset; it holds its value otherwise.
- Latency: req sampled at edge E0 gives grant visible after E0, CAPTURE after E1, oQ and ack valid after E2. Minimum cycles per transfer is 4 (IDLE, GRANT, CAPTURE, RELEASE), assuming the requester drops req on the cycle it sees ack.
- Simultaneous requests: exactly one is granted. The pointer rotation guarantees each pending requester is served within N_REQ transfers.
- Requester k re-asserting iReq in the cycle after RELEASE is treated as a new request. It is lower priority than the others because the pointer now equals k.
- Reset mid-transfer: the asynchronous clear wins and any in-flight capture is lost. Requesters must restart their handshake.
- oGrant, oAck and oEnable are all registered or decoded from state. They are glitch-free, and at most one bit of oGrant and of oAck is set.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, GRANT=2'd1, CAPTURE=2'd2, RELEASE=2'd3) and a log2 helper function for IDX_W.
- One sub-module: rr_pick. This is a combinational circular priority finder with inputs req[N_REQ] and pointer[IDX_W], and outputs idx[IDX_W] and valid.
- The oQ capture register is kept inline as a clock-enabled flop with asynchronous active-low clear.

Test Plan:
1. Reset with iReq=4'b1111 held: after release, oGrant sequence is 0001, 0010, 0100, 1000, 0001. Each transfer captures 8'hA0+k into oQ, and each requester drops req on its ack.
2. Single request, iReq=4'b0100, iData[2]=8'h5C: oGrant=0100 after E0, oEnable=1 in CAPTURE, oQ=8'h5C and oAck=0100 after E2, and oBusy stays high until req drops.
3. Abort: iReq[1] is raised, then lowered during GRANT. Required response: no oEnable, no oAck, oQ unchanged, and return to IDLE. The next request from 3 and 1 together is granted to requester 3.
4. Held request: requester 0 keeps iReq high for 5 cycles after ack. The FSM stays in RELEASE with oGrant=0001 and grants no other requester until iReq[0] falls.
5. Asynchronous reset asserted mid-CAPTURE while oQ=8'h33 is being loaded with 8'hFF: oQ=0 immediately, all outputs clear, and the first grant after reset goes to requester 0.
6. Fairness with N_REQ=4: requesters 0 and 3 re-request continuously for 20 transfers. Grants strictly alternate 0 and 3, and no requester is starved.

Source files
------------

// File: rtl/rr_enable_arbiter_pkg.sv
// rr_enable_arbiter_pkg: FSM state encoding and index-width helper shared by the arbiter files
package rr_enable_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      CAPTURE = 2'd2,
      RELEASE = 2'd3
   } state_t;
   function automatic int log2c(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin end
      return r;
   endfunction
endpackage

// File: rtl/rr_enable_arbiter_if.sv
// rr_enable_arbiter_if: requester/shared-register signals of the round-robin enable arbiter
interface rr_enable_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
);
   logic [N_REQ-1:0]        iReq;
   logic [N_REQ*DATA_W-1:0] iData;
   logic [N_REQ-1:0]        oGrant;
   logic [N_REQ-1:0]        oAck;
   logic                    oEnable;
   logic [DATA_W-1:0]       oQ;
   logic                    oBusy;
   modport master (output iReq, iData, input oGrant, oAck, oEnable, oQ, oBusy);
   modport slave  (input iReq, iData, output oGrant, oAck, oEnable, oQ, oBusy);
endinterface

// File: rtl/rr_enable_arbiter_pick.sv
// rr_pick: combinational circular priority finder starting just after ptr
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);
   logic [IDX_W-1:0] k;
   assign valid = |req;
   // walk from the farthest candidate back so the nearest one after ptr wins
   always_comb begin
      idx = '0;
      k   = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         k = IDX_W'((int'(ptr) + i) % N_REQ);
         if (req[k]) idx = k;
      end
   end
endmodule

// File: rtl/rr_enable_arbiter.sv
// rr_enable_arbiter: round-robin sequencer owning the enable of a shared capture register
module rr_enable_arbiter
   import rr_enable_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
) (
   input logic iClock,
   input logic iReset,
   rr_enable_arbiter_if.slave bus
);
   localparam int IDX_W = log2c(N_REQ);
   state_t           state_q, state_d;
   logic [IDX_W-1:0] win_q, win_d, ptr_q, ptr_d, pick_idx;
   logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
   logic [DATA_W-1:0] q_q, q_d;
   logic             pick_valid, en;
   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req  (bus.iReq),
      .ptr  (ptr_q),
      .idx  (pick_idx),
      .valid(pick_valid)
   );
   assign en = state_q == CAPTURE;
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      ack_d   = '0;
      q_d     = bus.iData[win_q*DATA_W +: DATA_W];
      case (state_q)
         IDLE: if (pick_valid) begin
            state_d = GRANT;
            win_d   = pick_idx;
            grant_d = N_REQ'(1) << pick_idx;
         end
         GRANT: if (bus.iReq[win_q]) state_d = CAPTURE;
         else begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = win_q;
         end
         CAPTURE: begin
            state_d = RELEASE;
            ack_d   = grant_q;
            ptr_d   = win_q;
         end
         RELEASE: if (!bus.iReq[win_q]) begin
            state_d = IDLE;
            grant_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q <= IDLE;
         win_q   <= '0;
         ptr_q   <= IDX_W'(N_REQ - 1);
         grant_q <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
      end
   end
   // shared data register: loads only on the CAPTURE edge
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) q_q <= '0;
      else if (en) q_q <= q_d;
   end
   assign bus.oGrant  = grant_q;
   assign bus.oAck    = ack_q;
   assign bus.oEnable = en;
   assign bus.oQ      = q_q;
   assign bus.oBusy   = state_q != IDLE;
endmodule

// File: tb/tb_rr_enable_arbiter.sv
// tb_rr_enable_arbiter: directed scenarios checked against a transfer-level model every cycle
module tb_rr_enable_arbiter;
   logic iClock = 1'b0;
   logic iReset = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   m_win = -1;
   int   m_phase = 0;
   int   m_ptr = 3;
   logic [7:0] m_q = 8'h00;
   logic [3:0] m_ack = 4'h0;
   int   w;
   logic [7:0] q;
   int   s1[5] = '{0, 1, 2, 3, 0};
   rr_enable_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();
   rr_enable_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
      .iClock(iClock),
      .iReset(iReset),
      .bus   (bus)
   );
   always #5 iClock = ~iClock;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic model_step();
      if (!iReset) begin
         m_win = -1; m_phase = 0; m_ptr = 3; m_q = 8'h00; m_ack = 4'h0;
      end else begin
         m_ack = 4'h0;
         if (m_win < 0) begin
            for (int i = 1; i <= 4; i++)
               if (m_win < 0 && bus.iReq[(m_ptr + i) % 4]) m_win = (m_ptr + i) % 4;
            m_phase = 1;
         end else if (m_phase == 1) begin
            if (bus.iReq[m_win]) m_phase = 2;
            else begin m_ptr = m_win; m_win = -1; end
         end else if (m_phase == 2) begin
            m_q = bus.iData[m_win*8 +: 8];
            m_ack = 4'(1 << m_win);
            m_ptr = m_win;
            m_phase = 3;
         end else if (!bus.iReq[m_win]) m_win = -1;
      end
   endtask
   always @(posedge iClock or negedge iReset) model_step();
   always @(negedge iClock) begin
      chk("m_grant", bus.oGrant, m_win >= 0 ? 32'(1 << m_win) : 32'd0);
      chk("m_ack", bus.oAck, m_ack);
      chk("m_enable", bus.oEnable, (m_win >= 0 && m_phase == 2) ? 1 : 0);
      chk("m_busy", bus.oBusy, m_win >= 0 ? 1 : 0);
      chk("m_q", bus.oQ, m_q);
   end
   task automatic wait_ack(output int wi);
      wi = -1;
      for (int c = 0; c < 20 && wi < 0; c++) begin
         @(negedge iClock);
         for (int k = 0; k < 4; k++) if (bus.oAck[k]) wi = k;
      end
      if (wi < 0) begin
         tests++;
         fails++;
         $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
      end
   endtask
   task automatic serve(input logic [3:0] keep, output int wi, output logic [7:0] qv);
      wait_ack(wi);
      qv = bus.oQ;
      if (wi >= 0) begin
         bus.iReq[wi] = 1'b0;
         @(negedge iClock);
         if (keep[wi]) bus.iReq[wi] = 1'b1;
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal;
   end
   initial begin
      bus.iReq  = 4'b1111;
      bus.iData = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      repeat (2) @(negedge iClock);
      chk("rst_grant", bus.oGrant, 0);
      chk("rst_busy", bus.oBusy, 0);
      chk("rst_q", bus.oQ, 0);
      iReset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         serve(4'b1111, w, q);
         chk("t1_win", w, s1[i]);
         chk("t1_q", q, 8'hA0 + s1[i]);
      end
      bus.iReq = 4'b0000;
      repeat (3) @(negedge iClock);
      bus.iData[23:16] = 8'h5C;
      bus.iReq = 4'b0100;
      @(negedge iClock);
      chk("t2_grant", bus.oGrant, 4'b0100);
      chk("t2_busy", bus.oBusy, 1);
      chk("t2_en_grant", bus.oEnable, 0);
      @(negedge iClock);
      chk("t2_en_cap", bus.oEnable, 1);
      chk("t2_ack_cap", bus.oAck, 0);
      @(negedge iClock);
      chk("t2_q", bus.oQ, 8'h5C);
      chk("t2_ack", bus.oAck, 4'b0100);
      chk("t2_en_rel", bus.oEnable, 0);
      @(negedge iClock);
      chk("t2_busy_hold", bus.oBusy, 1);
      chk("t2_ack_once", bus.oAck, 0);
      bus.iReq = 4'b0000;
      @(negedge iClock);
      chk("t2_idle", bus.oBusy, 0);
      bus.iData[23:16] = 8'hA2;
      bus.iReq = 4'b0001;
      wait_ack(w);
      chk("t4_win", w, 0);
      bus.iReq = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         @(negedge iClock);
         chk("t4_hold_grant", bus.oGrant, 4'b0001);
         chk("t4_hold_ack", bus.oAck, 0);
      end
      bus.iReq = 4'b1000;
      @(negedge iClock);
      chk("t4_idle_grant", bus.oGrant, 0);
      @(negedge iClock);
      chk("t4_next_grant", bus.oGrant, 4'b1000);
      wait_ack(w);
      chk("t4_win3", w, 3);
      bus.iReq = 4'b0000;
      @(negedge iClock);
      bus.iReq = 4'b0010;
      @(negedge iClock);
      chk("t3_grant", bus.oGrant, 4'b0010);
      chk("t3_en", bus.oEnable, 0);
      bus.iReq = 4'b0000;
      @(negedge iClock);
      chk("t3_abort_grant", bus.oGrant, 0);
      chk("t3_abort_busy", bus.oBusy, 0);
      chk("t3_abort_ack", bus.oAck, 0);
      chk("t3_abort_q", bus.oQ, 8'hA3);
      bus.iReq = 4'b1010;
      wait_ack(w);
      chk("t3_after_abort", w, 3);
      bus.iReq[3] = 1'b0;
      wait_ack(w);
      chk("t3_then_1", w, 1);
      bus.iReq = 4'b0000;
      @(negedge iClock);
      bus.iData[7:0] = 8'h33;
      bus.iReq = 4'b0001;
      wait_ack(w);
      chk("t5_win", w, 0);
      chk("t5_q33", bus.oQ, 8'h33);
      bus.iReq = 4'b0000;
      @(negedge iClock);
      bus.iData[7:0] = 8'hFF;
      bus.iReq = 4'b0001;
      @(negedge iClock);
      chk("t5_grant", bus.oGrant, 4'b0001);
      @(negedge iClock);
      chk("t5_en", bus.oEnable, 1);
      #2 iReset = 1'b0;
      #1;
      chk("t5_rst_q", bus.oQ, 0);
      chk("t5_rst_grant", bus.oGrant, 0);
      chk("t5_rst_en", bus.oEnable, 0);
      chk("t5_rst_busy", bus.oBusy, 0);
      chk("t5_rst_ack", bus.oAck, 0);
      bus.iReq = 4'b0011;
      @(negedge iClock);
      iReset = 1'b1;
      wait_ack(w);
      chk("t5_first", w, 0);
      chk("t5_qff", bus.oQ, 8'hFF);
      bus.iReq[0] = 1'b0;
      wait_ack(w);
      chk("t5_second", w, 1);
      bus.iReq = 4'b0000;
      bus.iData[7:0] = 8'hA0;
      @(negedge iClock);
      bus.iReq = 4'b1001;
      for (int i = 0; i < 20; i++) begin
         serve(4'b1001, w, q);
         chk("t6_win", w, (i % 2 == 0) ? 3 : 0);
         chk("t6_q", q, (i % 2 == 0) ? 8'hA3 : 8'hA0);
      end
      bus.iReq = 4'b0000;
      repeat (3) @(negedge iClock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
